// File: rtl/dmux_nway_reg.sv
// dmux_nway_reg
//   Registered 1-to-N demultiplexer with a valid/ready handshake on every
//   output channel. Each accepted input word is loaded into a one-deep
//   holding register on the selected channel, or into every channel when
//   broadcasting. An out-of-range unicast select is accepted, discarded and
//   recorded in a sticky error flag.
//
// Parameters
//   WIDTH  data width in bits (1..64)
//   WAYS   number of output channels (2..16, any value)
//   SEL_W  select width, derived from WAYS
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel index
//   in_bcast   1 = write word to every channel, in_sel ignored
//   in_valid   input word present
//   in_ready   block accepts the word this cycle (combinational)
//   out_data   channel k at [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a word
//   out_ready  consumer k takes the word this cycle
//   clr_err    synchronous clear of err_sel (a coincident set wins)
//   err_sel    sticky flag: an out-of-range select was dropped
module dmux_nway_reg #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WAYS*WIDTH-1:0] out_data,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  input  logic                  clr_err,
  output logic                  err_sel
);

  // Full decode space of in_sel; indices at or above WAYS are out of range.
  localparam int SEL_N = 1 << SEL_W;

  logic [WIDTH-1:0] data_q [WAYS];
  logic [WAYS-1:0]  valid_q;
  logic [WAYS-1:0]  free;
  logic [WAYS-1:0]  load;
  logic [SEL_N-1:0] in_range;
  logic [SEL_N-1:0] free_ext;
  logic             sel_ok;
  logic             accept;
  logic             err_set;

  // Handshake and load decode. The per-channel free vector is zero-extended
  // to the full select space so in_sel can index it directly; out-of-range
  // slots are masked by in_range and never gate in_ready.
  always_comb begin
    free     = ~valid_q | out_ready;
    free_ext = SEL_N'(free);
    in_range = SEL_N'({WAYS{1'b1}});
    sel_ok   = in_range[in_sel];

    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = free_ext[in_sel];
    end else begin
      in_ready = 1'b1;
    end

    accept = in_valid & in_ready;

    load = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      load[k] = accept & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
    end

    err_set = accept & ~in_bcast & ~sel_ok;
  end

  // Holding registers: load beats drain, so a load on a draining channel
  // replaces the word without a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < WAYS; k++) begin
        data_q[k] <= '0;
      end
      err_sel <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (load[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] & out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      err_sel <= err_set | (err_sel & ~clr_err);
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      out_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_dmux_nway_reg.sv
// Testbench for dmux_nway_reg: one 4-way instance tracked cycle by cycle
// against a channel-level reference model, plus a 5-way instance exercising
// out-of-range selects and the sticky error flag.
module tb_dmux_nway_reg;

  logic        clk;
  logic        reset_n;

  // 4-way instance
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        clr_err;
  logic        err_sel;

  // 5-way instance
  logic [15:0] in_data5;
  logic [2:0]  in_sel5;
  logic        in_bcast5;
  logic        in_valid5;
  logic        in_ready5;
  logic [79:0] out_data5;
  logic [4:0]  out_valid5;
  logic [4:0]  out_ready5;
  logic        clr_err5;
  logic        err_sel5;

  int checks = 0;
  int errors = 0;

  // Reference model of the 4-way instance: what each channel holds.
  logic [15:0] m_data  [4];
  bit          m_valid [4];
  bit          last_acc;

  dmux_nway_reg #(.WIDTH(16), .WAYS(4)) u4 (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clr_err(clr_err), .err_sel(err_sel)
  );

  dmux_nway_reg #(.WIDTH(16), .WAYS(5)) u5 (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data5), .in_sel(in_sel5), .in_bcast(in_bcast5),
    .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .clr_err(clr_err5), .err_sel(err_sel5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A channel can take a word if it is empty or its consumer drains it now;
  // a broadcast needs every channel able to take it.
  function automatic bit m_ready();
    bit r;
    r = 1'b1;
    if (in_bcast) begin
      for (int k = 0; k < 4; k++) if (m_valid[k] && !out_ready[k]) r = 1'b0;
    end else begin
      r = !m_valid[int'(in_sel)] || out_ready[int'(in_sel)];
    end
    return r;
  endfunction

  function automatic logic [63:0] m_out_data();
    logic [63:0] v;
    for (int k = 0; k < 4; k++) v[k*16 +: 16] = m_data[k];
    return v;
  endfunction

  function automatic logic [3:0] m_out_valid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_valid[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_data[k]  = '0;
      m_valid[k] = 1'b0;
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 128'(out_valid), 128'(m_out_valid()));
    chk("out_data",  128'(out_data),  128'(m_out_data()));
    chk("err_sel4",  128'(err_sel),   128'(0));
  endtask

  // One clock cycle: compare in_ready against the model before the edge,
  // advance the model with the pre-edge inputs, compare outputs after it.
  task automatic step();
    bit          rdy;
    bit          acc;
    logic [15:0] d;
    logic [1:0]  s;
    bit          b;
    logic [3:0]  r;
    #1;
    rdy = m_ready();
    chk("in_ready", 128'(in_ready), 128'(rdy));
    acc = in_valid && rdy;
    d = in_data; s = in_sel; b = in_bcast; r = out_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (acc && (b || int'(s) == k)) begin
        m_data[k]  = d;
        m_valid[k] = 1'b1;
      end else if (m_valid[k] && r[k]) begin
        m_valid[k] = 1'b0;
      end
    end
    last_acc = acc;
    check_outs();
  endtask

  initial begin
    logic [15:0] w;
    bit          stalled;

    reset_n = 1'b0;
    in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = '0; clr_err = 1'b0;
    in_data5 = '0; in_sel5 = '0; in_bcast5 = 1'b0; in_valid5 = 1'b0;
    out_ready5 = '0; clr_err5 = 1'b0;
    m_reset();
    last_acc = 1'b0;

    // Power-on reset
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_err5",      128'(err_sel5),  128'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Unicast routing, all consumers stalled
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel  = 2'(k);
      in_data = 16'h1111 * 16'(k + 1);
      step();
    end
    chk("route_valid", 128'(out_valid), 128'(4'b1111));
    chk("route_ch0", 128'(out_data[15:0]),  128'(16'h1111));
    chk("route_ch1", 128'(out_data[31:16]), 128'(16'h2222));
    chk("route_ch2", 128'(out_data[47:32]), 128'(16'h3333));
    chk("route_ch3", 128'(out_data[63:48]), 128'(16'h4444));
    in_sel = 2'd1; in_data = 16'h5555;
    #1;
    chk("full_stall_ready", 128'(in_ready), 128'(0));
    step();
    step();
    chk("full_stall_hold", 128'(out_data[31:16]), 128'(16'h2222));
    out_ready[1] = 1'b1;
    #1;
    chk("full_release_ready", 128'(in_ready), 128'(1));
    step();
    chk("full_release_data", 128'(out_data[31:16]), 128'(16'h5555));
    in_valid = 1'b0; out_ready = '0;

    // Back-to-back through channel 2 while it drains every cycle
    out_ready[2] = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'hA000 + 16'(i);
      #1;
      chk("b2b_ready", 128'(in_ready), 128'(1));
      step();
      chk("b2b_valid", 128'(out_valid[2]), 128'(1));
      chk("b2b_data",  128'(out_data[47:32]), 128'(16'hA000 + 16'(i)));
    end
    in_valid = 1'b0;

    // Broadcast gating: empty channels 0..2, channel 3 left full
    out_ready = 4'b0111;
    step();
    out_ready = 4'b0000;
    in_valid = 1'b1; in_bcast = 1'b1; in_sel = 2'd0; in_data = 16'hBEEF;
    #1;
    chk("bcast_stall_ready", 128'(in_ready), 128'(0));
    step();
    chk("bcast_stall_valid", 128'(out_valid), 128'(4'b1000));
    chk("bcast_stall_ch3", 128'(out_data[63:48]), 128'(16'h4444));
    out_ready[3] = 1'b1;
    #1;
    chk("bcast_go_ready", 128'(in_ready), 128'(1));
    step();
    chk("bcast_valid", 128'(out_valid), 128'(4'b1111));
    chk("bcast_data", 128'(out_data), 128'(64'hBEEF_BEEF_BEEF_BEEF));
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;

    // Randomized traffic against the model; a stalled request is held
    stalled = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bcast = ($urandom_range(0, 7) == 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 16'($urandom);
      end
      out_ready = 4'($urandom);
      step();
      stalled = in_valid && !last_acc;
    end
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;

    // Out-of-range selects on the 5-way instance
    in_valid5 = 1'b1; in_sel5 = 3'd6; in_data5 = 16'hDEAD;
    #1;
    chk("bad_ready", 128'(in_ready5), 128'(1));
    step();
    chk("bad_valid", 128'(out_valid5), 128'(0));
    chk("bad_err_set", 128'(err_sel5), 128'(1));
    in_sel5 = 3'd7; clr_err5 = 1'b1;
    step();
    chk("bad_set_wins", 128'(err_sel5), 128'(1));
    in_valid5 = 1'b0;
    step();
    chk("bad_clear", 128'(err_sel5), 128'(0));
    clr_err5 = 1'b0;
    in_valid5 = 1'b1; in_sel5 = 3'd4; in_data5 = 16'h4444;
    #1;
    chk("way4_ready", 128'(in_ready5), 128'(1));
    step();
    chk("way4_valid", 128'(out_valid5), 128'(5'b10000));
    chk("way4_data", 128'(out_data5[79:64]), 128'(16'h4444));
    chk("way4_no_err", 128'(err_sel5), 128'(0));
    in_valid5 = 1'b0; out_ready5 = 5'h1F;
    step();
    chk("way4_drain", 128'(out_valid5), 128'(0));
    out_ready5 = '0;
    in_valid5 = 1'b1; in_sel5 = 3'd5; in_data5 = 16'h0BAD;
    step();
    in_valid5 = 1'b0;
    chk("bad_err_again", 128'(err_sel5), 128'(1));

    // Mid-run reset with channels 0 and 2 full
    out_ready = 4'hF;
    step();
    out_ready = '0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hC0C0;
    step();
    in_sel = 2'd2; in_data = 16'hC2C2;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", 128'(out_valid), 128'(4'b0101));
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data",  128'(out_data),  128'(0));
    chk("mid_rst_err5",  128'(err_sel5),  128'(0));
    chk("mid_rst_valid5", 128'(out_valid5), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    in_bcast = 1'b1;
    #1;
    chk("post_rst_bcast_ready", 128'(in_ready), 128'(1));
    in_bcast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      #1;
      chk("post_rst_ready", 128'(in_ready), 128'(1));
    end
    step();
    chk("post_rst_idle", 128'(out_valid), 128'(0));
    in_valid = 1'b1; in_sel = 2'd3; in_data = 16'h1234;
    step();
    chk("post_rst_load", 128'(out_valid), 128'(4'b1000));
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux_nway_reg.md
# dmux_nway_reg

Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on every channel. One input stream carries data plus a select field. Each accepted word is steered into a one-deep holding register on the selected output channel, or into all channels in broadcast mode. It is the sequential, back-pressured successor to the combinational 4-way demux and is used wherever the CPU/memory datapath must fan one producer out to several consumers that can stall independently.

## Interface
- `WIDTH`, default 16: data width in bits (1..64).
- `WAYS`, default 4: number of output channels (2..16; need not be a power of two).
- `SEL_W`, default `$clog2(WAYS)`: select width; derived, never overridden.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; release is synchronised externally.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  SEL_W  destination channel index.
- `in_bcast`  in  1  1 = write word to every channel; `in_sel` ignored.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the word this cycle.
- `out_data`  out  WAYS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  WAYS  channel k holds a word.
- `out_ready`  in  WAYS  consumer k takes the word this cycle.
- `clr_err`  in  1  synchronous clear of `err_sel`.
- `err_sel`  out  1  sticky flag: an out-of-range select was dropped.

## Operation
- Each channel k has a holding register: `data_q[k]` (WIDTH) and `valid_q[k]`. It drives `out_data`/`out_valid` directly.
- Channel k is free when `!valid_q[k] | out_ready[k]` (empty, or draining this cycle).
- `in_ready`, which is combinational:
  - unicast with `in_sel < WAYS`: equals free[`in_sel`].
  - unicast with `in_sel >= WAYS`: 1. The word is accepted and discarded, and `err_sel` is set.
  - broadcast: AND of free[k] over all k. A broadcast never partially issues.
- Accept = `in_valid & in_ready`.
- Per-channel update on each edge, in priority order:
  1. Load (accept targets k): `data_q[k]` <= `in_data`, `valid_q[k]` <= 1.
  2. Otherwise drain (`valid_q[k] & out_ready[k]`): `valid_q[k]` <= 0. `data_q[k]` holds its value.
  3. Otherwise hold.
- Load and drain on the same edge means the new word replaces the old one and `valid_q` stays 1. No bubble is inserted.
- `err_sel`: set on accept of an out-of-range unicast. Cleared by `clr_err`. If set and clear occur on the same edge, set wins.
- The `out_ready` and `in_valid` levels are sampled only when they matter. Asserting `out_ready` on an empty channel has no effect.
- Producers must hold `in_data`/`in_sel`/`in_bcast` stable while `in_valid & !in_ready`. The block does not check this.

## Timing
- Reset (async assert): all `valid_q` = 0, all `data_q` = 0, `err_sel` = 0. Outputs reflect these values immediately, not at the next edge.
- `in_ready` after reset: 1 for every in-range or broadcast request.
- Latency: a word accepted at edge n is visible on `out_valid[k]`/`out_data` after edge n.
- Throughput: one word per cycle per channel when its consumer holds `out_ready` = 1.
- `in_ready` has a combinational path from `out_ready` and `in_sel`/`in_bcast`. There is no path from `in_valid`.
- Reset asserted mid-transfer: held words are lost, and no channel shows `out_valid` until a new accept occurs after release.
- Full boundary: channel k valid with `out_ready[k]` = 0 means unicast to k stalls and broadcast stalls. Unicasts to other channels proceed.

## Test plan
- **Reset values.** WIDTH=16, WAYS=4. Assert `reset_n` = 0 mid-run with channels 0 and 2 full. Then `out_valid` = 4'b0000, `out_data` = 0, `err_sel` = 0 with no clock edge. After release, `in_ready` = 1.
- **Unicast routing.** Send 0x1111/sel 0, 0x2222/sel 1, 0x3333/sel 2, 0x4444/sel 3 on consecutive cycles, all `out_ready` = 0. Then `out_valid` = 4'b1111 and each slice holds its word. A fifth word to sel 1 sees `in_ready` = 0 until `out_ready[1]` = 1.
- **Back-to-back with drain.** Hold `out_ready[2]` = 1 and stream 0xA000..0xA007 to sel 2. Then `in_ready` stays 1, `out_valid[2]` stays 1, and the words appear in order, one per cycle, one cycle late.
- **Broadcast gating.** Channel 3 is full and `out_ready[3]` = 0. Send a broadcast of 0xBEEF. Then `in_ready` = 0 and no channel changes. Raise `out_ready[3]` and the word is accepted: all four channels hold 0xBEEF the next cycle.
- **Bad select.** WAYS=5 (SEL_W=3). Send sel 6 with 0xDEAD. Then `in_ready` = 1, no `out_valid` change, and `err_sel` = 1. Pulse `clr_err` together with another sel 7 and `err_sel` stays 1. A lone `clr_err` makes it 0.
